// File: rtl/gem_csc_cluster_match_pkg.sv
// GEM-CSC cluster match: shared sizes, FSM states, bundles.
// Also holds the per-cluster acceptance rule used by both CLCT trackers.
package gem_csc_cluster_match_pkg;

  localparam int MXCLST  = 8;
  localparam int MXCLSTB = 3;
  localparam int MXKEYB  = 10;
  localparam int OFSB    = 8;

  localparam logic [MXKEYB-1:0] DEFMAXDELTA = 10'd20;
  localparam logic [MXCLSTB-1:0] IDXLAST =
    MXCLSTB'(MXCLST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [MXKEYB-1:0] xky;
    logic              outedge;
    logic [OFSB-1:0]   ofs;
  } tgt_t;

  typedef struct packed {
    logic vpf;
    tgt_t a;
    tgt_t b;
  } clct_t;

  typedef struct packed {
    logic               match;
    logic [MXCLSTB-1:0] idx;
    logic               lyr;
    logic [MXKEYB-1:0]  delta;
  } best_t;

  localparam best_t BESTINIT = '{
    match: 1'b0,
    idx:   '0,
    lyr:   1'b0,
    delta: '1
  };

  // Strict less-than keeps the lowest index on ties.
  function automatic logic accept(
    input logic              vld,
    input logic              vpf,
    input logic [MXKEYB-1:0] d,
    input logic [MXKEYB-1:0] maxD,
    input best_t             best
  );
    return vld & vpf & (d <= maxD) &
           (!best.match | (d < best.delta));
  endfunction

endpackage

// File: rtl/gem_csc_cluster_match_if.sv
// GEM-CSC cluster match request/result bundle.
// master drives the request, slave is the matcher.
interface gem_csc_cluster_match_if;
  import gem_csc_cluster_match_pkg::*;

  logic start;
  logic busy;
  logic done;

  logic clct0_vpf;
  logic clct1_vpf;

  logic [MXKEYB-1:0] clct0_gemA_xky;
  logic [MXKEYB-1:0] clct0_gemB_xky;
  logic [MXKEYB-1:0] clct1_gemA_xky;
  logic [MXKEYB-1:0] clct1_gemB_xky;

  logic clct0_gemA_outedge;
  logic clct0_gemB_outedge;
  logic clct1_gemA_outedge;
  logic clct1_gemB_outedge;

  logic [OFSB-1:0] clct0_gemA_edgeoffset;
  logic [OFSB-1:0] clct0_gemB_edgeoffset;
  logic [OFSB-1:0] clct1_gemA_edgeoffset;
  logic [OFSB-1:0] clct1_gemB_edgeoffset;

  logic [MXCLST-1:0]        gem_vld;
  logic [MXCLST-1:0]        gem_lyr;
  logic [MXCLST*MXKEYB-1:0] gem_xky;

  logic               clct0_match;
  logic               clct1_match;
  logic [MXCLSTB-1:0] clct0_match_idx;
  logic [MXCLSTB-1:0] clct1_match_idx;
  logic               clct0_match_lyr;
  logic               clct1_match_lyr;
  logic [MXKEYB-1:0]  clct0_match_delta;
  logic [MXKEYB-1:0]  clct1_match_delta;

  modport master (
    output start,
    output clct0_vpf, clct1_vpf,
    output clct0_gemA_xky, clct0_gemB_xky,
    output clct1_gemA_xky, clct1_gemB_xky,
    output clct0_gemA_outedge, clct0_gemB_outedge,
    output clct1_gemA_outedge, clct1_gemB_outedge,
    output clct0_gemA_edgeoffset,
    output clct0_gemB_edgeoffset,
    output clct1_gemA_edgeoffset,
    output clct1_gemB_edgeoffset,
    output gem_vld, gem_lyr, gem_xky,
    input  busy, done,
    input  clct0_match, clct1_match,
    input  clct0_match_idx, clct1_match_idx,
    input  clct0_match_lyr, clct1_match_lyr,
    input  clct0_match_delta, clct1_match_delta
  );

  modport slave (
    input  start,
    input  clct0_vpf, clct1_vpf,
    input  clct0_gemA_xky, clct0_gemB_xky,
    input  clct1_gemA_xky, clct1_gemB_xky,
    input  clct0_gemA_outedge, clct0_gemB_outedge,
    input  clct1_gemA_outedge, clct1_gemB_outedge,
    input  clct0_gemA_edgeoffset,
    input  clct0_gemB_edgeoffset,
    input  clct1_gemA_edgeoffset,
    input  clct1_gemB_edgeoffset,
    input  gem_vld, gem_lyr, gem_xky,
    output busy, done,
    output clct0_match, clct1_match,
    output clct0_match_idx, clct1_match_idx,
    output clct0_match_lyr, clct1_match_lyr,
    output clct0_match_delta, clct1_match_delta
  );

endinterface

// File: rtl/gem_csc_delta.sv
// Distance from one GEM cluster to a CLCT's extrapolated key.
// Picks gemA/gemB target by layer; edge-clipped targets add the offset.
module gem_csc_delta
  import gem_csc_cluster_match_pkg::*;
(
  input  logic              gemLyr,
  input  logic [MXKEYB-1:0] gemXky,
  input  tgt_t              tgtA,
  input  tgt_t              tgtB,
  output logic [MXKEYB-1:0] delta
);

  tgt_t              tgt;
  logic [MXKEYB:0]   diff;
  logic [MXKEYB:0]   mag;
  logic [MXKEYB:0]   sum;
  logic [MXKEYB:0]   raw;

  always_comb begin
    tgt  = gemLyr ? tgtB : tgtA;
    diff = {1'b0, gemXky} - {1'b0, tgt.xky};
    mag  = diff[MXKEYB] ? -diff : diff;
    sum  = {1'b0, gemXky} +
           {{(MXKEYB+1-OFSB){1'b0}}, tgt.ofs};
    raw  = tgt.outedge ? sum : mag;
    delta = raw[MXKEYB] ? '1 : raw[MXKEYB-1:0];
  end

endmodule

// File: rtl/gem_csc_cluster_match.sv
// Scans latched GEM clusters one per clock and keeps the closest
// in-window cluster for each of two CLCTs.
module gem_csc_cluster_match
  import gem_csc_cluster_match_pkg::*;
#(
  parameter logic [MXKEYB-1:0] MAXDELTA = DEFMAXDELTA
) (
  input logic clock,
  input logic reset_n,
  gem_csc_cluster_match_if.slave bus
);

  state_t state;
  state_t stateNext;

  logic [MXCLSTB-1:0] idx;
  clct_t              c0;
  clct_t              c1;
  clct_t              in0;
  clct_t              in1;
  logic [MXCLST-1:0]  gemVldL;
  logic [MXCLST-1:0]  gemLyrL;
  logic [MXKEYB-1:0]  gemXkyL [MXCLST];

  best_t best0;
  best_t best1;
  best_t out0;
  best_t out1;
  logic  doneR;

  logic              curVld;
  logic              curLyr;
  logic [MXKEYB-1:0] curXky;
  logic [MXKEYB-1:0] d0;
  logic [MXKEYB-1:0] d1;
  logic              acc0;
  logic              acc1;

  assign in0 = {
    bus.clct0_vpf,
    bus.clct0_gemA_xky,
    bus.clct0_gemA_outedge,
    bus.clct0_gemA_edgeoffset,
    bus.clct0_gemB_xky,
    bus.clct0_gemB_outedge,
    bus.clct0_gemB_edgeoffset
  };

  assign in1 = {
    bus.clct1_vpf,
    bus.clct1_gemA_xky,
    bus.clct1_gemA_outedge,
    bus.clct1_gemA_edgeoffset,
    bus.clct1_gemB_xky,
    bus.clct1_gemB_outedge,
    bus.clct1_gemB_edgeoffset
  };

  assign curVld = gemVldL[idx];
  assign curLyr = gemLyrL[idx];
  assign curXky = gemXkyL[idx];

  gem_csc_delta u_delta0 (
    .gemLyr (curLyr),
    .gemXky (curXky),
    .tgtA   (c0.a),
    .tgtB   (c0.b),
    .delta  (d0)
  );

  gem_csc_delta u_delta1 (
    .gemLyr (curLyr),
    .gemXky (curXky),
    .tgtA   (c1.a),
    .tgtB   (c1.b),
    .delta  (d1)
  );

  assign acc0 = accept(curVld, c0.vpf, d0,
                       MAXDELTA, best0);
  assign acc1 = accept(curVld, c1.vpf, d1,
                       MAXDELTA, best1);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (bus.start) stateNext = SCAN;
      SCAN: if (idx == IDXLAST) stateNext = DONE;
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      idx     <= '0;
      c0      <= '0;
      c1      <= '0;
      gemVldL <= '0;
      gemLyrL <= '0;
      for (int i = 0; i < MXCLST; i++) begin
        gemXkyL[i] <= '0;
      end
      best0 <= '0;
      best1 <= '0;
      out0  <= '0;
      out1  <= '0;
      doneR <= 1'b0;
    end else begin
      doneR <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            c0      <= in0;
            c1      <= in1;
            gemVldL <= bus.gem_vld;
            gemLyrL <= bus.gem_lyr;
            for (int i = 0; i < MXCLST; i++) begin
              gemXkyL[i] <=
                bus.gem_xky[i*MXKEYB +: MXKEYB];
            end
            idx   <= '0;
            best0 <= BESTINIT;
            best1 <= BESTINIT;
          end
        end
        SCAN: begin
          idx <= idx + MXCLSTB'(1);
          if (acc0) best0 <= '{1'b1, idx, curLyr, d0};
          if (acc1) best1 <= '{1'b1, idx, curLyr, d1};
        end
        DONE: begin
          // Unmatched results read as all-zero.
          out0  <= best0.match ? best0 : '0;
          out1  <= best1.match ? best1 : '0;
          doneR <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = doneR;

  assign bus.clct0_match       = out0.match;
  assign bus.clct0_match_idx   = out0.idx;
  assign bus.clct0_match_lyr   = out0.lyr;
  assign bus.clct0_match_delta = out0.delta;
  assign bus.clct1_match       = out1.match;
  assign bus.clct1_match_idx   = out1.idx;
  assign bus.clct1_match_lyr   = out1.lyr;
  assign bus.clct1_match_delta = out1.delta;

endmodule

// File: tb/tb_gem_csc_cluster_match.sv
// Bench for gem_csc_cluster_match: table vectors, handshake/reset
// sequences, and random requests against a distance model.
module tb_gem_csc_cluster_match;
  import gem_csc_cluster_match_pkg::*;

  typedef struct packed {
    logic       match;
    logic [2:0] idx;
    logic       lyr;
    logic [9:0] delta;
  } res_t;

  typedef struct {
    logic [1:0] vpf;
    logic [9:0] tgt [2][2];
    logic       oe  [2][2];
    logic [7:0] off [2][2];
    logic [7:0] vld;
    logic [7:0] lyr;
    logic [9:0] gx  [8];
  } stim_t;

  typedef struct {
    string name;
    stim_t s;
    res_t  e0;
    res_t  e1;
  } vec_t;

  logic clk = 1'b0;
  logic rstN;
  int   nChk = 0;
  int   nFail = 0;

  always #5 clk = ~clk;

  gem_csc_cluster_match_if bus ();
  gem_csc_cluster_match_if busW ();

  gem_csc_cluster_match dut (
    .clock   (clk),
    .reset_n (rstN),
    .bus     (bus.slave)
  );

  gem_csc_cluster_match #(.MAXDELTA(10'd1023)) dutW (
    .clock   (clk),
    .reset_n (rstN),
    .bus     (busW.slave)
  );

  assign busW.start = bus.start;
  assign busW.clct0_vpf = bus.clct0_vpf;
  assign busW.clct1_vpf = bus.clct1_vpf;
  assign busW.clct0_gemA_xky = bus.clct0_gemA_xky;
  assign busW.clct0_gemB_xky = bus.clct0_gemB_xky;
  assign busW.clct1_gemA_xky = bus.clct1_gemA_xky;
  assign busW.clct1_gemB_xky = bus.clct1_gemB_xky;
  assign busW.clct0_gemA_outedge = bus.clct0_gemA_outedge;
  assign busW.clct0_gemB_outedge = bus.clct0_gemB_outedge;
  assign busW.clct1_gemA_outedge = bus.clct1_gemA_outedge;
  assign busW.clct1_gemB_outedge = bus.clct1_gemB_outedge;
  assign busW.clct0_gemA_edgeoffset = bus.clct0_gemA_edgeoffset;
  assign busW.clct0_gemB_edgeoffset = bus.clct0_gemB_edgeoffset;
  assign busW.clct1_gemA_edgeoffset = bus.clct1_gemA_edgeoffset;
  assign busW.clct1_gemB_edgeoffset = bus.clct1_gemB_edgeoffset;
  assign busW.gem_vld = bus.gem_vld;
  assign busW.gem_lyr = bus.gem_lyr;
  assign busW.gem_xky = bus.gem_xky;

  function automatic stim_t blank();
    stim_t s;
    s.vpf = '0;
    for (int c = 0; c < 2; c++) begin
      for (int l = 0; l < 2; l++) begin
        s.tgt[c][l] = '0;
        s.oe[c][l]  = 1'b0;
        s.off[c][l] = '0;
      end
    end
    s.vld = '0;
    s.lyr = '0;
    for (int i = 0; i < 8; i++) s.gx[i] = '0;
    return s;
  endfunction

  function automatic logic [9:0] clip(input int v);
    if (v < 0) return 10'd0;
    if (v > 1023) return 10'd1023;
    return 10'(v);
  endfunction

  function automatic stim_t rndStim();
    stim_t s;
    int    base;
    base = ($urandom_range(0, 3) == 0) ?
           int'($urandom_range(0, 15)) :
           int'($urandom_range(0, 1023));
    for (int c = 0; c < 2; c++) begin
      s.vpf[c] = ($urandom_range(0, 4) != 0);
      for (int l = 0; l < 2; l++) begin
        s.tgt[c][l] = clip(base +
                           int'($urandom_range(0, 80)) - 40);
        s.oe[c][l]  = ($urandom_range(0, 3) == 0);
        s.off[c][l] = ($urandom_range(0, 7) == 0) ? 8'd255 :
                      8'($urandom_range(0, 30));
      end
    end
    s.vld = 8'($urandom);
    s.lyr = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      s.gx[i] = clip(base + int'($urandom_range(0, 80)) - 40);
    end
    return s;
  endfunction

  // Closest valid cluster within maxD; first index wins ties.
  function automatic res_t model(input stim_t s, input int c,
                                 input int maxD);
    res_t r;
    int   d;
    int   l;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (s.vld[i] && s.vpf[c]) begin
        l = int'(s.lyr[i]);
        if (s.oe[c][l]) begin
          d = int'(s.gx[i]) + int'(s.off[c][l]);
          if (d > 1023) d = 1023;
        end else begin
          d = int'(s.gx[i]) - int'(s.tgt[c][l]);
          if (d < 0) d = -d;
        end
        if (d <= maxD && (!r.match || d < int'(r.delta))) begin
          r.match = 1'b1;
          r.idx   = i[2:0];
          r.lyr   = l[0];
          r.delta = d[9:0];
        end
      end
    end
    return r;
  endfunction

  task automatic drive(input stim_t s);
    bus.clct0_vpf = s.vpf[0];
    bus.clct1_vpf = s.vpf[1];
    bus.clct0_gemA_xky = s.tgt[0][0];
    bus.clct0_gemB_xky = s.tgt[0][1];
    bus.clct1_gemA_xky = s.tgt[1][0];
    bus.clct1_gemB_xky = s.tgt[1][1];
    bus.clct0_gemA_outedge = s.oe[0][0];
    bus.clct0_gemB_outedge = s.oe[0][1];
    bus.clct1_gemA_outedge = s.oe[1][0];
    bus.clct1_gemB_outedge = s.oe[1][1];
    bus.clct0_gemA_edgeoffset = s.off[0][0];
    bus.clct0_gemB_edgeoffset = s.off[0][1];
    bus.clct1_gemA_edgeoffset = s.off[1][0];
    bus.clct1_gemB_edgeoffset = s.off[1][1];
    bus.gem_vld = s.vld;
    bus.gem_lyr = s.lyr;
    for (int i = 0; i < 8; i++) bus.gem_xky[i*10 +: 10] = s.gx[i];
  endtask

  function automatic res_t rd(input bit w, input bit c);
    if (!w && !c)
      return {bus.clct0_match, bus.clct0_match_idx,
              bus.clct0_match_lyr, bus.clct0_match_delta};
    if (!w)
      return {bus.clct1_match, bus.clct1_match_idx,
              bus.clct1_match_lyr, bus.clct1_match_delta};
    if (!c)
      return {busW.clct0_match, busW.clct0_match_idx,
              busW.clct0_match_lyr, busW.clct0_match_delta};
    return {busW.clct1_match, busW.clct1_match_idx,
            busW.clct1_match_lyr, busW.clct1_match_delta};
  endfunction

  task automatic chkRes(input string nm, input res_t g,
                        input res_t e);
    nChk++;
    if (g !== e) begin
      nFail++;
      $display("FAIL %s: got m=%0b i=%0d l=%0b d=%0d, want m=%0b i=%0d l=%0b d=%0d",
               nm, g.match, g.idx, g.lyr, g.delta,
               e.match, e.idx, e.lyr, e.delta);
    end
  endtask

  task automatic chkInt(input string nm, input int g, input int e);
    nChk++;
    if (g != e) begin
      nFail++;
      $display("FAIL %s: got %0d, want %0d", nm, g, e);
    end
  endtask

  task automatic runReq(input string nm, input stim_t s,
                        input res_t e0, input res_t e1,
                        input res_t w0, input res_t w1);
    int doneEdge;
    int busyCnt;
    doneEdge = -1;
    busyCnt  = 0;
    @(negedge clk);
    drive(s);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    if (bus.busy) busyCnt++;
    @(negedge clk);
    bus.start = 1'b0;
    drive(rndStim());
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.busy) busyCnt++;
      if (bus.done) begin
        doneEdge = k;
        break;
      end
    end
    chkInt({nm, " doneEdge"}, doneEdge, 9);
    chkInt({nm, " busyCycles"}, busyCnt, 9);
    chkRes({nm, " clct0"}, rd(0, 0), e0);
    chkRes({nm, " clct1"}, rd(0, 1), e1);
    chkRes({nm, " wide clct0"}, rd(1, 0), w0);
    chkRes({nm, " wide clct1"}, rd(1, 1), w1);
    @(posedge clk);
    #1;
    chkInt({nm, " donePulse"}, int'(bus.done), 0);
  endtask

  vec_t   tbl[9];
  stim_t  s;
  res_t   at9;
  res_t   at19;
  int     doneEdges[$];
  int     sawDone;

  initial begin
    rstN = 1'b0;
    bus.start = 1'b0;
    drive(blank());

    s = blank();
    s.vpf = 2'b01; s.tgt[0][0] = 10'd100;
    s.vld[3] = 1'b1; s.gx[3] = 10'd100;
    tbl[0] = '{"exact", s, '{1'b1, 3'd3, 1'b0, 10'd0}, '0};

    s = blank();
    s.vpf = 2'b01; s.tgt[0][0] = 10'd200;
    s.vld[0] = 1'b1; s.gx[0] = 10'd220;
    tbl[1] = '{"win20", s, '{1'b1, 3'd0, 1'b0, 10'd20}, '0};
    s.gx[0] = 10'd221;
    tbl[2] = '{"win21", s, '0, '0};

    s = blank();
    s.vpf = 2'b11;
    s.tgt[0][0] = 10'd50; s.tgt[0][1] = 10'd60;
    s.tgt[1][0] = 10'd50; s.tgt[1][1] = 10'd60;
    s.vld[1] = 1'b1; s.gx[1] = 10'd55;
    s.vld[5] = 1'b1; s.lyr[5] = 1'b1; s.gx[5] = 10'd55;
    tbl[3] = '{"tie", s, '{1'b1, 3'd1, 1'b0, 10'd5},
               '{1'b1, 3'd1, 1'b0, 10'd5}};

    s = blank();
    s.vpf = 2'b10; s.oe[1][0] = 1'b1; s.off[1][0] = 8'd6;
    s.vld[0] = 1'b1; s.gx[0] = 10'd4;
    tbl[4] = '{"outedge", s, '0, '{1'b1, 3'd0, 1'b0, 10'd10}};
    s.vpf = 2'b00;
    tbl[5] = '{"outedgeNoVpf", s, '0, '0};

    s = blank();
    s.vpf = 2'b01;
    s.vld[0] = 1'b1; s.gx[0] = 10'd1023;
    tbl[6] = '{"sat", s, '0, '0};

    s = blank();
    s.vpf = 2'b11;
    s.tgt[0][0] = 10'd300; s.tgt[0][1] = 10'd500;
    s.tgt[1][0] = 10'd500; s.tgt[1][1] = 10'd300;
    s.vld[2] = 1'b1; s.lyr[2] = 1'b1; s.gx[2] = 10'd510;
    s.vld[4] = 1'b1; s.gx[4] = 10'd303;
    tbl[7] = '{"layerB", s, '{1'b1, 3'd4, 1'b0, 10'd3}, '0};

    s = tbl[0].s;
    s.vld = '0;
    tbl[8] = '{"invalid", s, '0, '0};

    repeat (2) @(posedge clk);
    #1;
    chkInt("rst busy", int'(bus.busy), 0);
    chkInt("rst done", int'(bus.done), 0);
    chkRes("rst clct0", rd(0, 0), '0);
    chkRes("rst clct1", rd(0, 1), '0);
    @(negedge clk);
    rstN = 1'b1;

    for (int v = 0; v < 9; v++) begin
      runReq(tbl[v].name, tbl[v].s, tbl[v].e0, tbl[v].e1,
             model(tbl[v].s, 0, 1023), model(tbl[v].s, 1, 1023));
    end

    // Saturated distance only passes the widest window.
    runReq("satWide", tbl[6].s, '0, '0,
           '{1'b1, 3'd0, 1'b0, 10'd1023}, '0);

    // start ignored while busy; next accepted after done.
    @(negedge clk);
    drive(tbl[0].s);
    bus.start = 1'b1;
    @(posedge clk);
    at9  = '0;
    at19 = '0;
    for (int e = 1; e <= 25; e++) begin
      @(negedge clk);
      bus.start = (e == 4) || (e == 10);
      if (e == 4 || e == 10) drive(tbl[1].s);
      @(posedge clk);
      #1;
      if (bus.done) begin
        doneEdges.push_back(e);
        if (e == 9) at9 = rd(0, 0);
        if (e == 19) at19 = rd(0, 0);
      end
    end
    bus.start = 1'b0;
    chkInt("hs doneCount", doneEdges.size(), 2);
    chkInt("hs firstDone",
           (doneEdges.size() > 0) ? doneEdges[0] : -1, 9);
    chkInt("hs secondDone",
           (doneEdges.size() > 1) ? doneEdges[1] : -1, 19);
    chkRes("hs first result", at9, tbl[0].e0);
    chkRes("hs second result", at19, tbl[1].e0);

    // Reset during scan aborts and clears held results.
    @(negedge clk);
    drive(tbl[0].s);
    bus.start = 1'b1;
    @(posedge clk);
    sawDone = 0;
    for (int e = 1; e <= 15; e++) begin
      @(negedge clk);
      bus.start = 1'b0;
      rstN = (e != 5);
      @(posedge clk);
      #1;
      if (bus.done) sawDone++;
      if (e == 5) begin
        chkInt("midRst busy", int'(bus.busy), 0);
        chkRes("midRst clct0", rd(0, 0), '0);
        chkRes("midRst clct1", rd(0, 1), '0);
      end
    end
    chkInt("midRst noDone", sawDone, 0);

    for (int r = 0; r < 40; r++) begin
      s = rndStim();
      runReq($sformatf("rnd%0d", r), s,
             model(s, 0, 20), model(s, 1, 20),
             model(s, 0, 1023), model(s, 1, 1023));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChk, nFail);
    $finish;
  end

endmodule
